decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipelined, parametrised RV32I decode stage between fetch and execute.
- Buffers fetched instruction/PC pairs in a small instruction FIFO and decodes the FIFO head into a widened control word plus an XLEN-wide sign-extended immediate.
- Presents the decoded result in a registered output slot with a valid/ready handshake.
- Adds a load-use interlock (one-bubble insertion), pipeline flush, U-type (LUI/AUIPC) decode and illegal-opcode flagging.

Parameters:
- XLEN, 32, width of PC and immediate; legal values 32 or 64.
- IBUF_DEPTH, 4, instruction FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  equals FIFO not full.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  discard all buffered and output state.
- out_valid  out  1  output slot holds a decoded instruction.
- out_ready  in  1  execute accepts the slot.
- out_pc  out  XLEN  PC of the decoded instruction.
- out_ctrl  out  15  control word (layout below).
- out_imm  out  XLEN  sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_funct3  out  3  instr[14:12], passed through.
- out_illegal  out  1  opcode is not decoded.
- ibuf_count  out  $clog2(IBUF_DEPTH)+1  FIFO occupancy.

Behaviour:

Reset:
- All outputs and state go to 0: out_valid=0, FIFO empty, hazard_pending=0.
- in_ready=1 after reset.

Control word layout, by bit:
- [3:0] ALU op: add=0, sub=8, sll=1, slt=2, sltu=3, xor=4, srl=5, sra=13, or=6, and=7.
- [4] alusrc, [5] regwrite, [6] memtoreg, [7] memwrite, [8] memread, [9] branch, [10] jalr, [11] jal, [12] bne, [13] lui, [14] auipc.

Decode, combinational on the FIFO head:
- JAL: jal, regwrite; J-immediate.
- Branch: branch, ALU sub, bne=funct3[0]; B-immediate.
- Store: memwrite, alusrc, ALU add; S-immediate.
- Load: memread, memtoreg, regwrite, alusrc, ALU add; I-immediate.
- JALR: jalr, regwrite, alusrc, ALU add; I-immediate.
- OP-IMM: regwrite, alusrc; ALU op from funct3, with instr[30] selecting sra vs srl. For shifts the immediate is shamt (instr[24:20]) zero-extended.
- OP: regwrite; ALU op from funct3, with instr[30] selecting sub vs add and sra vs srl.
- LUI / AUIPC: lui or auipc set, regwrite, alusrc; U-immediate is {instr[31:12], 12'b0} sign-extended to XLEN.
- Any other opcode: ctrl=0, out_illegal=1. The instruction is still issued in order.
- regwrite is forced to 0 when rd==0.

FIFO:
- Push when in_valid && in_ready && !flush.
- in_ready depends on registered occupancy only. There is no pass-through when full: a pop in the same cycle does not raise in_ready.
- Simultaneous push and pop keeps the count unchanged.
- Pointers wrap modulo IBUF_DEPTH.

Output slot advance:
- The slot advances when !out_valid || out_ready.
- On advance with the FIFO non-empty and no hazard: load the decoded head, pop it, set out_valid=1.
- On advance with the FIFO empty: out_valid goes to 0.
- While out_valid && !out_ready, all output fields hold stable and nothing pops.
- Latency: an instruction pushed at edge N, into an empty FIFO and a free slot, appears on the outputs after edge N+1.

Load-use interlock:
- Issuing a load with rd!=0 sets hazard_pending and records load_rd.
- Hazard condition: hazard_pending and the head uses load_rd. The head uses rs1 for all formats except JAL/LUI/AUIPC, and uses rs2 for branch/store/OP.
- On a hazard, the advance loads a bubble (out_valid=0, no pop) and clears hazard_pending. The head issues at the next advance.
- hazard_pending also clears on any advance that issues a non-load.

Flush:
- Takes effect at the next edge: FIFO emptied, out_valid=0, hazard_pending=0.
- A push or pop in the flush cycle is discarded.
- Flush has priority over all other events.

Reset mid-operation: asynchronous; returns to the reset state immediately.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - ALU op codes;
  - CTRL_W=15 and named control-bit indices;
  - a decoded-instruction struct (ctrl, imm, rs1, rs2, rd, funct3, illegal).
- Sub-module decode_ibuf: parametrised synchronous FIFO with flush and count. The decode function and interlock stay in decode_stage.

Test Plan:
1. Reset, then push 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, ctrl alusrc|regwrite with ALU op 0, out_imm=5, out_rd=1.
2. Push 0xFE000EE3 (beq x0,x0,-4) → branch=1, bne=0, ALU op 8, out_imm=0xFFFFFFFC (XLEN=32) or 0xFFFF_FFFF_FFFF_FFFC (XLEN=64).
3. Push lw x5,0(x1), then add x6,x5,x2 back-to-back → load issues, then one cycle with out_valid=0, then the add issues. Repeat with add x6,x7,x2 → no bubble.
4. Hold out_ready=0 and push 5 instructions with IBUF_DEPTH=4 → in_ready drops when ibuf_count=4, out fields stay stable, and no instruction is lost or duplicated after out_ready=1.
5. Assert flush with 3 buffered instructions and out_valid=1 → next cycle out_valid=0, ibuf_count=0; a push in the flush cycle is dropped.
6. Push 0x12345037 (lui x0) and 0xFFFFFFFF → lui=1 with regwrite=0 and imm=0x12345000; second gives out_illegal=1 and ctrl=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage.
// Holds the opcode constants, the ALU op codes, the control-word bit indices
// and the decoded-instruction payload struct.
package decode_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned CTRL_W   = 15;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU op codes: low three bits mirror funct3, bit 3 is the alternate form
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd13;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;

    // Control-word bit indices (ALU op occupies [3:0])
    localparam int unsigned CB_ALUSRC   = 4;
    localparam int unsigned CB_REGWRITE = 5;
    localparam int unsigned CB_MEMTOREG = 6;
    localparam int unsigned CB_MEMWRITE = 7;
    localparam int unsigned CB_MEMREAD  = 8;
    localparam int unsigned CB_BRANCH   = 9;
    localparam int unsigned CB_JALR     = 10;
    localparam int unsigned CB_JAL      = 11;
    localparam int unsigned CB_BNE      = 12;
    localparam int unsigned CB_LUI      = 13;
    localparam int unsigned CB_AUIPC    = 14;

    // Decoded instruction; imm is held at the widest XLEN and truncated by users
    typedef struct packed {
        logic [CTRL_W-1:0]   ctrl;
        logic [XLEN_MAX-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic                illegal;
    } dec_instr_t;

    // ALU op from funct3; instr[30] picks sra over srl, and sub over add for OP
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b30,
                                          input logic is_op);
        logic alt;
        alt = b30 && ((f3 == 3'd5) || (is_op && (f3 == 3'd0)));
        return {alt, f3};
    endfunction

endpackage

// File: rtl/decode_ibuf.sv
// Instruction FIFO for the decode stage.
// Ports: clk, rst_n, flush (empties the FIFO at the next edge), push/wdata,
// pop/rdata (rdata is the current head), count (occupancy), full, empty.
module decode_ibuf #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = count_q;

    // Storage, pointers (wrap naturally at the power-of-two depth) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: buffers fetched instr/PC pairs, decodes the FIFO head
// into a control word and sign-extended immediate, and presents it in a
// registered valid/ready output slot with a one-bubble load-use interlock.
// Ports: clk, rst_n; fetch side in_valid/in_ready/in_instr/in_pc; flush;
// execute side out_valid/out_ready and the decoded fields out_pc, out_ctrl,
// out_imm, out_rs1, out_rs2, out_rd, out_funct3, out_illegal; ibuf_count.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    input  logic [XLEN-1:0]               in_pc,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [CTRL_W-1:0]             out_ctrl,
    output logic [XLEN-1:0]               out_imm,
    output logic [4:0]                    out_rs1,
    output logic [4:0]                    out_rs2,
    output logic [4:0]                    out_rd,
    output logic [2:0]                    out_funct3,
    output logic                          out_illegal,
    output logic [$clog2(IBUF_DEPTH):0]   ibuf_count
);

    localparam int unsigned ENTRY_W = 32 + XLEN;

    logic [ENTRY_W-1:0] head;
    logic [31:0]        head_instr;
    logic [XLEN-1:0]    head_pc;
    logic               ibuf_full;
    logic               ibuf_empty;
    logic               push;
    logic               pop;
    logic               advance;
    logic               hazard;
    logic               hazard_pending;
    logic [4:0]         load_rd;

    dec_instr_t         dec;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               is_load;

    assign in_ready   = !ibuf_full;
    assign push       = in_valid && in_ready && !flush;
    assign advance    = !out_valid || out_ready;
    assign head_instr = head[31:0];
    assign head_pc    = head[ENTRY_W-1:32];

    decode_ibuf #(
        .WIDTH (ENTRY_W),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata ({in_pc, in_instr}),
        .pop   (pop),
        .rdata (head),
        .count (ibuf_count),
        .full  (ibuf_full),
        .empty (ibuf_empty)
    );

    // Combinational decode of the FIFO head
    always_comb begin
        logic [6:0]          opc;
        logic [XLEN_MAX-1:0] imm_i;
        logic [XLEN_MAX-1:0] imm_s;
        logic [XLEN_MAX-1:0] imm_b;
        logic [XLEN_MAX-1:0] imm_j;
        logic [XLEN_MAX-1:0] imm_u;

        dec      = '0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        is_load  = 1'b0;

        opc   = head_instr[6:0];
        imm_i = {{52{head_instr[31]}}, head_instr[31:20]};
        imm_s = {{52{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
        imm_b = {{52{head_instr[31]}}, head_instr[7], head_instr[30:25],
                 head_instr[11:8], 1'b0};
        imm_j = {{44{head_instr[31]}}, head_instr[19:12], head_instr[20],
                 head_instr[30:21], 1'b0};
        imm_u = {{32{head_instr[31]}}, head_instr[31:12], 12'b0};

        dec.rs1    = head_instr[19:15];
        dec.rs2    = head_instr[24:20];
        dec.rd     = head_instr[11:7];
        dec.funct3 = head_instr[14:12];

        case (opc)
            OPC_JAL: begin
                dec.ctrl[CB_JAL]      = 1'b1;
                dec.ctrl[CB_REGWRITE] = 1'b1;
                dec.imm               = imm_j;
                uses_rs1              = 1'b0;
            end
            OPC_BRANCH: begin
                dec.ctrl[CB_BRANCH] = 1'b1;
                dec.ctrl[CB_BNE]    = head_instr[12];
                dec.ctrl[3:0]       = ALU_SUB;
                dec.imm             = imm_b;
                uses_rs2            = 1'b1;
            end
            OPC_STORE: begin
                dec.ctrl[CB_MEMWRITE] = 1'b1;
                dec.ctrl[CB_ALUSRC]   = 1'b1;
                dec.ctrl[3:0]         = ALU_ADD;
                dec.imm               = imm_s;
                uses_rs2              = 1'b1;
            end
            OPC_LOAD: begin
                dec.ctrl[CB_MEMREAD]  = 1'b1;
                dec.ctrl[CB_MEMTOREG] = 1'b1;
                dec.ctrl[CB_REGWRITE] = 1'b1;
                dec.ctrl[CB_ALUSRC]   = 1'b1;
                dec.ctrl[3:0]         = ALU_ADD;
                dec.imm               = imm_i;
                is_load               = 1'b1;
            end
            OPC_JALR: begin
                dec.ctrl[CB_JALR]     = 1'b1;
                dec.ctrl[CB_REGWRITE] = 1'b1;
                dec.ctrl[CB_ALUSRC]   = 1'b1;
                dec.ctrl[3:0]         = ALU_ADD;
                dec.imm               = imm_i;
            end
            OPC_OP_IMM: begin
                dec.ctrl[CB_REGWRITE] = 1'b1;
                dec.ctrl[CB_ALUSRC]   = 1'b1;
                dec.ctrl[3:0]         = alu_op(head_instr[14:12], head_instr[30], 1'b0);
                // Shifts take the zero-extended shamt instead of the I-immediate
                if (head_instr[13:12] == 2'b01) begin
                    dec.imm = XLEN_MAX'(head_instr[24:20]);
                end else begin
                    dec.imm = imm_i;
                end
            end
            OPC_OP: begin
                dec.ctrl[CB_REGWRITE] = 1'b1;
                dec.ctrl[3:0]         = alu_op(head_instr[14:12], head_instr[30], 1'b1);
                uses_rs2              = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.ctrl[CB_LUI]      = (opc == OPC_LUI);
                dec.ctrl[CB_AUIPC]    = (opc == OPC_AUIPC);
                dec.ctrl[CB_REGWRITE] = 1'b1;
                dec.ctrl[CB_ALUSRC]   = 1'b1;
                dec.imm               = imm_u;
                uses_rs1              = 1'b0;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        if (dec.rd == 5'd0) begin
            dec.ctrl[CB_REGWRITE] = 1'b0;
        end
    end

    // Immediate bits above XLEN are discarded when XLEN is narrower than the struct
    if (XLEN < XLEN_MAX) begin : g_imm_hi
        logic unused_imm_hi;
        assign unused_imm_hi = ^dec.imm[XLEN_MAX-1:XLEN];
    end

    // Load-use: a pending load's rd matches a register the head actually reads
    assign hazard = hazard_pending && !ibuf_empty &&
                    ((uses_rs1 && (dec.rs1 == load_rd)) ||
                     (uses_rs2 && (dec.rs2 == load_rd)));

    assign pop = advance && !ibuf_empty && !hazard && !flush;

    // Output slot and interlock state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_ctrl       <= '0;
            out_imm        <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_funct3     <= '0;
            out_illegal    <= 1'b0;
            hazard_pending <= 1'b0;
            load_rd        <= '0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            hazard_pending <= 1'b0;
        end else if (advance) begin
            if (ibuf_empty) begin
                out_valid <= 1'b0;
            end else if (hazard) begin
                out_valid      <= 1'b0;
                hazard_pending <= 1'b0;
            end else begin
                out_valid      <= 1'b1;
                out_pc         <= head_pc;
                out_ctrl       <= dec.ctrl;
                out_imm        <= dec.imm[XLEN-1:0];
                out_rs1        <= dec.rs1;
                out_rs2        <= dec.rs2;
                out_rd         <= dec.rd;
                out_funct3     <= dec.funct3;
                out_illegal    <= dec.illegal;
                hazard_pending <= is_load && (dec.rd != 5'd0);
                if (is_load) begin
                    load_rd <= dec.rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of decoded vectors streamed
// through a scoreboard, plus hand-written latency, interlock, backpressure,
// flush and asynchronous-reset sequences.
module tb_decode_stage;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned IBUF_DEPTH = 4;
    localparam int unsigned NVEC       = 14;

    typedef struct {
        logic [31:0] instr;
        logic [14:0] ctrl;
        logic [63:0] imm;
        logic        chk_imm;
        logic        illegal;
    } vec_t;

    typedef struct {
        vec_t            v;
        logic [XLEN-1:0] pc;
    } sb_t;

    logic                        clk;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    logic [31:0]                 in_instr;
    logic [XLEN-1:0]             in_pc;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [XLEN-1:0]             out_pc;
    logic [14:0]                 out_ctrl;
    logic [XLEN-1:0]             out_imm;
    logic [4:0]                  out_rs1;
    logic [4:0]                  out_rs2;
    logic [4:0]                  out_rd;
    logic [2:0]                  out_funct3;
    logic                        out_illegal;
    logic [$clog2(IBUF_DEPTH):0] ibuf_count;

    int              tests;
    int              fails;
    int              handshakes;
    sb_t             q[$];
    vec_t            cur;
    logic [XLEN-1:0] pc_next;
    vec_t            vecs[NVEC];

    decode_stage #(
        .XLEN       (XLEN),
        .IBUF_DEPTH (IBUF_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_ctrl    (out_ctrl),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_funct3  (out_funct3),
        .out_illegal (out_illegal),
        .ibuf_count  (ibuf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [14:0] ctrl,
                                input logic [63:0] imm, input logic chk_imm,
                                input logic illegal);
        vec_t v;
        v.instr   = instr;
        v.ctrl    = ctrl;
        v.imm     = imm;
        v.chk_imm = chk_imm;
        v.illegal = illegal;
        return v;
    endfunction

    // addi x1, x0, k
    function automatic vec_t mk_addi(input int k);
        return mk(32'h0000_0093 | (32'(k) << 20), 15'h0030, 64'(k), 1'b1, 1'b0);
    endfunction

    task automatic drive(input vec_t v);
        cur      = v;
        in_instr = v.instr;
        in_pc    = pc_next;
        in_valid = 1'b1;
        pc_next  = pc_next + XLEN'(4);
    endtask

    // Score the pre-edge handshakes, then advance one clock and settle
    task automatic tick();
        sb_t e;
        if (!flush && out_valid && out_ready) begin
            handshakes++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got pc %h expected no issue", out_pc);
            end else begin
                e = q.pop_front();
                chk("issue_pc", 64'(out_pc), 64'(e.pc));
                chk("issue_ctrl", 64'(out_ctrl), 64'(e.v.ctrl));
                if (e.v.chk_imm) chk("issue_imm", 64'(out_imm), 64'(e.v.imm[XLEN-1:0]));
                chk("issue_rs1", 64'(out_rs1), 64'(e.v.instr[19:15]));
                chk("issue_rs2", 64'(out_rs2), 64'(e.v.instr[24:20]));
                chk("issue_rd", 64'(out_rd), 64'(e.v.instr[11:7]));
                chk("issue_funct3", 64'(out_funct3), 64'(e.v.instr[14:12]));
                chk("issue_illegal", 64'(out_illegal), 64'(e.v.illegal));
            end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back('{v: cur, pc: in_pc});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Back-to-back pair with out_ready high; returns out_valid after 5 edges
    task automatic pair_seq(input vec_t a, input vec_t b, output logic [4:0] pat);
        out_ready = 1'b1;
        drive(a);
        tick();
        pat[4] = out_valid;
        drive(b);
        tick();
        pat[3] = out_valid;
        in_valid = 1'b0;
        tick();
        pat[2] = out_valid;
        tick();
        pat[1] = out_valid;
        tick();
        pat[0] = out_valid;
    endtask

    initial begin
        logic [4:0] pat;
        int         accepted;
        int         hs0;
        vec_t       v_lw;
        vec_t       v_add_dep;
        vec_t       v_add_ind;

        tests      = 0;
        fails      = 0;
        handshakes = 0;
        pc_next    = XLEN'(32'h1000);
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_pc      = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;

        vecs[0]  = mk(32'h0050_0093, 15'h0030, 64'd5, 1'b1, 1'b0);                  // addi x1,x0,5
        vecs[1]  = mk(32'hFE00_0EE3, 15'h0208, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0); // beq -4
        vecs[2]  = mk(32'h0000_A283, 15'h0170, 64'd0, 1'b1, 1'b0);                  // lw x5,0(x1)
        vecs[3]  = mk(32'h1234_5037, 15'h2010, 64'h0000_0000_1234_5000, 1'b1, 1'b0);// lui x0
        vecs[4]  = mk(32'hFFFF_FFFF, 15'h0000, 64'd0, 1'b0, 1'b1);                  // illegal
        vecs[5]  = mk(32'h0020_A423, 15'h0090, 64'd8, 1'b1, 1'b0);                  // sw x2,8(x1)
        vecs[6]  = mk(32'h0100_00EF, 15'h0820, 64'd16, 1'b1, 1'b0);                 // jal x1,16
        vecs[7]  = mk(32'h0000_8067, 15'h0410, 64'd0, 1'b1, 1'b0);                  // jalr x0,0(x1)
        vecs[8]  = mk(32'h4032_5193, 15'h003D, 64'd3, 1'b1, 1'b0);                  // srai x3,x4,3
        vecs[9]  = mk(32'h4052_01B3, 15'h0028, 64'd0, 1'b0, 1'b0);                  // sub x3,x4,x5
        vecs[10] = mk(32'h8000_0397, 15'h4030, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0);// auipc x7
        vecs[11] = mk(32'h0020_9463, 15'h1208, 64'd8, 1'b1, 1'b0);                  // bne x1,x2,8
        vecs[12] = mk(32'hFFF0_A113, 15'h0032, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);// slti x2,x1,-1
        vecs[13] = mk(32'h0020_B233, 15'h0023, 64'd0, 1'b0, 1'b0);                  // sltu x4,x1,x2

        v_lw      = vecs[2];
        v_add_dep = mk(32'h0022_8333, 15'h0020, 64'd0, 1'b0, 1'b0);                 // add x6,x5,x2
        v_add_ind = mk(32'h0023_8333, 15'h0020, 64'd0, 1'b0, 1'b0);                 // add x6,x7,x2

        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ibuf_count", 64'(ibuf_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single-instruction latency: pushed at edge N, visible after edge N+1
        drive(vecs[0]);
        tick();
        in_valid = 1'b0;
        chk("lat_valid_n", 64'(out_valid), 64'd0);
        chk("lat_count_n", 64'(ibuf_count), 64'd1);
        tick();
        chk("lat_valid_n1", 64'(out_valid), 64'd1);
        chk("lat_ctrl", 64'(out_ctrl), 64'h30);
        chk("lat_imm", 64'(out_imm), 64'd5);
        chk("lat_rd", 64'(out_rd), 64'd1);
        idle(3);

        // Streamed decode table
        out_ready = 1'b1;
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i]);
            tick();
        end
        idle(6);
        chk("table_drained", 64'(q.size()), 64'd0);

        // Load-use with dependency: one bubble
        pair_seq(v_lw, v_add_dep, pat);
        chk("loaduse_bubble_pattern", 64'(pat), 64'(5'b01010));
        idle(2);
        // Independent follower: no bubble
        pair_seq(v_lw, v_add_ind, pat);
        chk("loaduse_nobubble_pattern", 64'(pat), 64'(5'b01100));
        idle(2);
        chk("loaduse_drained", 64'(q.size()), 64'd0);

        // Backpressure: slot plus four FIFO entries, then full
        out_ready = 1'b0;
        accepted  = 0;
        hs0       = handshakes;
        for (int c = 0; c < 20 && accepted < 5; c++) begin
            drive(mk_addi(accepted + 1));
            if (in_ready) accepted++;
            tick();
        end
        chk("bp_accepted", 64'(accepted), 64'd5);
        drive(mk_addi(6));
        for (int c = 0; c < 2; c++) begin
            chk("bp_in_ready_full", 64'(in_ready), 64'd0);
            chk("bp_count_full", 64'(ibuf_count), 64'd4);
            chk("bp_slot_valid", 64'(out_valid), 64'd1);
            chk("bp_slot_imm", 64'(out_imm), 64'd1);
            chk("bp_slot_pc", 64'(out_pc), 64'(pc_next - XLEN'(24)));
            tick();
        end
        out_ready = 1'b1;
        chk("bp_no_passthrough", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        idle(10);
        chk("bp_issued", 64'(handshakes - hs0), 64'd5);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Flush with three buffered and the slot occupied
        out_ready = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            drive(mk_addi(k));
            tick();
        end
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        chk("fl_pre_count", 64'(ibuf_count), 64'd3);
        flush = 1'b1;
        drive(mk_addi(11));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_count", 64'(ibuf_count), 64'd0);
        idle(3);
        chk("fl_push_dropped", 64'(out_valid), 64'd0);
        chk("fl_count_stays", 64'(ibuf_count), 64'd0);
        out_ready = 1'b1;
        hs0       = handshakes;
        drive(mk_addi(12));
        tick();
        idle(4);
        chk("fl_after_issued", 64'(handshakes - hs0), 64'd1);
        chk("fl_drained", 64'(q.size()), 64'd0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        for (int k = 13; k <= 15; k++) begin
            drive(mk_addi(k));
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(ibuf_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_hold_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
